// File: rtl/adau_spi_xfer_pkg.sv
// Shared definitions for the ADAU1761 control-port SPI master.
//   state_t            : transfer FSM encoding
//   ADAU_CHIP_ADDR_WR  : chip-address byte that opens a register write
//   ADAU_CHIP_ADDR_RD  : chip-address byte that opens a register read
package adau_spi_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } state_t;

  localparam logic [7:0] ADAU_CHIP_ADDR_WR = 8'h00;
  localparam logic [7:0] ADAU_CHIP_ADDR_RD = 8'h01;

endpackage

// File: rtl/adau_spi_xfer_tick_gen.sv
// Divider producing a one-cycle tick every DIV enabled clk cycles.
// Shared by the SPI master and the I2S block.
//   clk     : system clock
//   reset_n : asynchronous reset, active-low
//   en      : count while high; counter holds while low
//   clr     : synchronous clear, wins over en
//   tick    : high in the cycle where the counter sits at DIV-1
module spi_tick_gen #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/adau_spi_xfer.sv
// Variable-length SPI master for the ADAU1761 control port (CPOL=0).
// Sends 1..MAX_BYTES bytes MSB first and captures COUT for read-back.
//   clk       : system clock
//   reset_n   : asynchronous reset, active-low
//   cmd_data  : transmit word, left-aligned (bit 8*MAX_BYTES-1 goes first)
//   cmd_len   : transfer length in bytes; 0 or >MAX_BYTES is answered empty
//   cmd_valid : command valid
//   cmd_ready : command accepted when high together with cmd_valid
//   rsp_data  : received bits, right-aligned, upper bits zero
//   rsp_valid : one-cycle response strobe
//   cclk      : SPI clock, registered
//   cdata     : MOSI, registered
//   cout      : MISO, already synchronous to clk
//   clatch_n  : chip select, active-low, registered
module adau_spi_xfer
  import adau_spi_xfer_pkg::*;
#(
  parameter int CLK_DIV   = 6,
  parameter int MAX_BYTES = 4,
  parameter int LATCH_GAP = 1,
  localparam int LEN_BITS = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*MAX_BYTES-1:0] cmd_data,
  input  logic [LEN_BITS-1:0]    cmd_len,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [8*MAX_BYTES-1:0] rsp_data,
  output logic                   rsp_valid,
  output logic                   cclk,
  output logic                   cdata,
  input  logic                   cout,
  output logic                   clatch_n
);

  localparam int W     = 8 * MAX_BYTES;
  // {cmd_len, 3'b000} is exactly wide enough to hold 8*MAX_BYTES.
  localparam int CNT_W = LEN_BITS + 3;
  localparam int GAP_W = (LATCH_GAP > 1) ? $clog2(LATCH_GAP + 1) : 1;

  state_t             state_q, state_d;
  logic [W-1:0]       tx_q, tx_d;
  logic [W-1:0]       rx_q, rx_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               cclk_q, cclk_d;
  logic               cdata_q, cdata_d;
  logic               clatch_q, clatch_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_data_q, rsp_data_d;

  logic tick;
  logic accept;
  logic len_ok;

  assign accept = cmd_valid && ready_q && (state_q == IDLE);
  assign len_ok = (cmd_len != '0) && (cmd_len <= LEN_BITS'(MAX_BYTES));

  // Half-period timebase: idle while waiting, restarted on every accept so
  // the LEAD phase is always a full half-period.
  spi_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q != IDLE),
    .clr     (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    cclk_d      = cclk_q;
    cdata_d     = cdata_q;
    clatch_d    = clatch_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          if (len_ok) begin
            tx_d      = cmd_data;
            rx_d      = '0;
            bit_cnt_d = {cmd_len, 3'b000};
            clatch_d  = 1'b0;
            cdata_d   = cmd_data[W-1];
            state_d   = LEAD;
          end else begin
            // Bad length: answer at once with an empty response, pins untouched.
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end
      LEAD: begin
        if (tick) begin
          cclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        // Codec drives COUT on the falling edge, so sample at the end of high.
        if (tick) begin
          rx_d      = {rx_q[W-2:0], cout};
          tx_d      = {tx_q[W-2:0], 1'b0};
          cdata_d   = tx_q[W-2];
          cclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          state_d   = (bit_cnt_q == CNT_W'(1)) ? TRAIL : LOW;
        end
      end
      LOW: begin
        if (tick) begin
          cclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      TRAIL: begin
        if (tick) begin
          clatch_d  = 1'b1;
          cdata_d   = 1'b0;
          gap_cnt_d = GAP_W'(LATCH_GAP);
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_W'(1)) begin
            // rx was cleared at accept, so only the N received bits are set.
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
            ready_d     = 1'b1;
            state_d     = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      cclk_q      <= 1'b0;
      cdata_q     <= 1'b0;
      clatch_q    <= 1'b1;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      cclk_q      <= cclk_d;
      cdata_q     <= cdata_d;
      clatch_q    <= clatch_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Shift registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cclk      = cclk_q;
  assign cdata     = cdata_q;
  assign clatch_n  = clatch_q;

endmodule

// File: tb/tb_adau_spi_xfer.sv
module tb_adau_spi_xfer;

  localparam int CLK_DIV   = 6;
  localparam int MAX_BYTES = 4;
  localparam int LATCH_GAP = 1;

  logic        clk;
  logic        reset_n;
  logic [31:0] cmd_data;
  logic [2:0]  cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        cclk;
  logic        cdata;
  logic        cout;
  logic        clatch_n;

  int n_checks;
  int n_pass;
  int n_fail;

  adau_spi_xfer #(
    .CLK_DIV   (CLK_DIV),
    .MAX_BYTES (MAX_BYTES),
    .LATCH_GAP (LATCH_GAP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .cclk      (cclk),
    .cdata     (cdata),
    .cout      (cout),
    .clatch_n  (clatch_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command and return right after the accepting clock edge.
  task automatic send(input logic [31:0] d, input logic [2:0] l);
    int w;
    @(negedge clk);
    cmd_data  = d;
    cmd_len   = l;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
  endtask

  // Observe one transfer, cycle by cycle, starting in the cycle after accept.
  // Acts as the codec: after rising cclk number r it drives miso[n_bits-r].
  task automatic watch(
    input  int          n_bits,
    input  logic [31:0] miso,
    input  int          abort_at,
    input  logic        keep_valid,
    input  logic [31:0] nd,
    input  logic [2:0]  nl,
    output int          rises,
    output logic [31:0] cap,
    output int          low_cnt,
    output int          last_low_c,
    output int          rsp_c,
    output logic [31:0] rsp_d,
    output logic        rdy_at_rsp,
    output logic        first_low,
    output int          min_hi,
    output int          max_hi,
    output int          min_lo,
    output logic        cdata_bad,
    output logic        aborted
  );
    logic pcclk, pcdata;
    int   hi_run, lo_run, idx;
    bit   seen_rise;
    rises = 0; cap = '0; low_cnt = 0; last_low_c = -1; rsp_c = -1; rsp_d = '0;
    rdy_at_rsp = 1'b0; first_low = 1'b0; min_hi = 1000; max_hi = 0; min_lo = 1000;
    cdata_bad = 1'b0; aborted = 1'b0;
    pcclk = cclk; pcdata = cdata; hi_run = 0; lo_run = 0; seen_rise = 0;
    cout = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cmd_valid = keep_valid;
        if (keep_valid) begin
          cmd_data = nd;
          cmd_len  = nl;
        end
        first_low = !clatch_n;
      end
      if (!clatch_n) begin
        low_cnt++;
        last_low_c = c;
      end
      if (c > 0 && cdata !== pcdata) begin
        if (pcclk && cclk) cdata_bad = 1'b1;
        if (!clatch_n && !(pcclk && !cclk)) cdata_bad = 1'b1;
      end
      if (cclk && !pcclk) begin
        rises++;
        cap = {cap[30:0], cdata};
        if (seen_rise && lo_run < min_lo) min_lo = lo_run;
        seen_rise = 1;
        hi_run = 0;
        idx = n_bits - rises;
        if (idx >= 0 && idx < 32) cout = miso[idx];
      end
      if (cclk) hi_run++;
      if (!cclk && pcclk) begin
        if (hi_run < min_hi) min_hi = hi_run;
        if (hi_run > max_hi) max_hi = hi_run;
        lo_run = 0;
      end
      if (!cclk) lo_run++;
      pcclk  = cclk;
      pcdata = cdata;
      if (rsp_valid) begin
        rsp_c      = c;
        rsp_d      = rsp_data;
        rdy_at_rsp = cmd_ready;
        break;
      end
      if (abort_at > 0 && rises == abort_at) begin
        #1 reset_n = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
  endtask

  int          rises, low_cnt, last_low_c, rsp_c, min_hi, max_hi, min_lo;
  logic [31:0] cap, rsp_d;
  logic        rdy_at_rsp, first_low, cdata_bad, aborted;

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0; cout = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",     32'(cmd_ready), 32'd0);
    check("rst_cclk",      32'(cclk),      32'd0);
    check("rst_clatch_n",  32'(clatch_n),  32'd1);
    check("rst_cdata",     32'(cdata),     32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    reset_n = 1'b1;
    #1 check("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(cmd_ready), 32'd1);
    check("idle_clatch_n",    32'(clatch_n),  32'd1);

    // Single byte 0xA5
    send(32'hA5FF_0000, 3'd1);
    watch(8, 32'h0, 0, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("b1_first_low", 32'(first_low), 32'd1);
    check("b1_low_cnt",   low_cnt,        32'd102);
    check("b1_rises",     rises,          32'd8);
    check("b1_bits",      {24'h0, cap[7:0]}, 32'h0000_00A5);
    check("b1_min_hi",    min_hi,         32'd6);
    check("b1_max_hi",    max_hi,         32'd6);
    check("b1_min_lo",    min_lo,         32'd6);
    check("b1_cdata_ok",  32'(cdata_bad), 32'd0);
    check("b1_rsp_cyc",   rsp_c,          32'd108);
    check("b1_rsp_data",  rsp_d,          32'h0);
    check("b1_rdy_rsp",   32'(rdy_at_rsp), 32'd1);
    @(negedge clk);
    check("b1_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("b1_end_cclk",  32'(cclk),      32'd0);

    // Full 4-byte read-back
    send(32'h0140_0000, 3'd4);
    watch(32, 32'h0000_003C, 0, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("rd_rises",    rises,          32'd32);
    check("rd_bits",     cap,            32'h0140_0000);
    check("rd_low_cnt",  low_cnt,        32'd390);
    check("rd_rsp_cyc",  rsp_c,          32'd396);
    check("rd_rsp_data", rsp_d,          32'h0000_003C);
    check("rd_cdata_ok", 32'(cdata_bad), 32'd0);

    // Two-byte transfer
    send(32'hC35A_FFFF, 3'd2);
    watch(16, 32'h0000_BEEF, 0, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("b2_rises",    rises,            32'd16);
    check("b2_bits",     {16'h0, cap[15:0]}, 32'h0000_C35A);
    check("b2_low_cnt",  low_cnt,          32'd198);
    check("b2_rsp_cyc",  rsp_c,            32'd204);
    check("b2_rsp_data", rsp_d,            32'h0000_BEEF);

    // Invalid lengths 0 and 5
    send(32'hFFFF_FFFF, 3'd0);
    cout = 1'b1;
    watch(0, 32'h0, 0, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("len0_rsp_cyc",  rsp_c,           32'd0);
    check("len0_rsp_data", rsp_d,           32'h0);
    check("len0_low",      low_cnt,         32'd0);
    check("len0_rdy_rsp",  32'(rdy_at_rsp), 32'd0);
    @(negedge clk);
    check("len0_pulse",    32'(rsp_valid),  32'd0);
    check("len0_ready",    32'(cmd_ready),  32'd1);
    send(32'hFFFF_FFFF, 3'd5);
    watch(0, 32'h0, 0, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("len5_rsp_cyc",  rsp_c,           32'd0);
    check("len5_rsp_data", rsp_d,           32'h0);
    check("len5_low",      low_cnt,         32'd0);
    check("len5_rises",    rises,           32'd0);
    @(negedge clk);
    check("len5_cdata",    32'(cdata),      32'd0);

    // Reset after the third rising cclk, then a clean 4-byte transfer
    send(32'h5A0F_C381, 3'd4);
    watch(32, 32'h1234_5678, 3, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("mr_aborted", 32'(aborted), 32'd1);
    #1;
    check("mr_clatch_n", 32'(clatch_n),  32'd1);
    check("mr_cclk",     32'(cclk),      32'd0);
    check("mr_ready",    32'(cmd_ready), 32'd0);
    check("mr_rsp_data", rsp_data,       32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mr_ready_back", 32'(cmd_ready), 32'd1);
    send(32'h5A0F_C381, 3'd4);
    watch(32, 32'h1234_5678, 0, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("mr_rises",    rises, 32'd32);
    check("mr_bits",     cap,   32'h5A0F_C381);
    check("mr_rsp_cyc",  rsp_c, 32'd396);
    check("mr_rsp_data", rsp_d, 32'h1234_5678);

    // Back-to-back with cmd_valid held high
    send(32'h3C00_0000, 3'd1);
    watch(8, 32'h0000_0081, 0, 1'b1, 32'hC600_0000, 3'd1, rises, cap, low_cnt, last_low_c, rsp_c,
          rsp_d, rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("bb1_bits",     {24'h0, cap[7:0]}, 32'h0000_003C);
    check("bb1_rsp_cyc",  rsp_c,             32'd108);
    check("bb1_rsp_data", rsp_d,             32'h0000_0081);
    check("bb1_rdy_rsp",  32'(rdy_at_rsp),   32'd1);
    check("bb_gap_high",  rsp_c - last_low_c, LATCH_GAP * CLK_DIV + 1);
    @(posedge clk);
    watch(8, 32'h0000_007E, 0, 1'b0, 32'h0, 3'd0, rises, cap, low_cnt, last_low_c, rsp_c, rsp_d,
          rdy_at_rsp, first_low, min_hi, max_hi, min_lo, cdata_bad, aborted);
    check("bb2_first_low", 32'(first_low),   32'd1);
    check("bb2_bits",      {24'h0, cap[7:0]}, 32'h0000_00C6);
    check("bb2_low_cnt",   low_cnt,          32'd102);
    check("bb2_rsp_cyc",   rsp_c,            32'd108);
    check("bb2_rsp_data",  rsp_d,            32'h0000_007E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
